// File: rtl/rtc_pkg.sv
// Shared types, field widths and helpers for the real-time clock controller.
package rtc_pkg;

    localparam int HR_W   = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam int TIME_W = HR_W + MIN_W + SEC_W;

    localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_SET_HR  = 3'd1,
        ST_SET_MIN = 3'd2,
        ST_SET_SEC = 3'd3,
        ST_ALM_HR  = 3'd4,
        ST_ALM_MIN = 3'd5
    } rtc_state_e;

    typedef struct packed {
        logic [HR_W-1:0]  hh;
        logic [MIN_W-1:0] mm;
        logic [SEC_W-1:0] ss;
    } rtc_time_t;

    function automatic rtc_time_t unpack_time(input logic [TIME_W-1:0] raw);
        return rtc_time_t'(raw);
    endfunction

    function automatic logic [TIME_W-1:0] pack_time(input rtc_time_t t);
        return {t.hh, t.mm, t.ss};
    endfunction

    // Out-of-range values also fall back to zero so a bad cur_time cannot stick.
    function automatic logic [HR_W-1:0] wrap_inc_hr(input logic [HR_W-1:0] v);
        return (v >= HR_MAX) ? '0 : v + 5'd1;
    endfunction

    function automatic logic [5:0] wrap_inc_60(input logic [5:0] v, input logic [5:0] lim);
        return (v >= lim) ? '0 : v + 6'd1;
    endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// 1 Hz count-enable generator: pcnt runs 0..TICK_DIV-1 while enabled, held at 0 otherwise.
module rtc_prescaler #(
    parameter int TICK_DIV = 100000000
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    output logic tick_o
);

    localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;

    // Next count: wrap at terminal count, park at zero while disabled.
    always_comb begin
        pcnt_d = '0;
        if (en_i && (pcnt_q != PMAX)) begin
            pcnt_d = pcnt_q + PW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    assign tick_o = en_i && (pcnt_q == PMAX);

endmodule

// File: rtl/rtc_ctrl.sv
// Real-time clock sequencer: set-mode FSM, time/alarm edit register, load pulse and alarm ring.
//
//  state      | meaning
//  -----------+-------------------------------------------------
//  ST_RUN     | clock counting, ticks issued, alarm may ring
//  ST_SET_HR  | editing hours of new time
//  ST_SET_MIN | editing minutes of new time
//  ST_SET_SEC | editing seconds; leaving loads the counter
//  ST_ALM_HR  | editing alarm hours
//  ST_ALM_MIN | editing alarm minutes; leaving arms the alarm
module rtc_ctrl
    import rtc_pkg::*;
#(
    parameter int TICK_DIV   = 100000000,
    parameter int RING_TICKS = 60
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic [TIME_W-1:0] cur_time,
    output logic              tick,
    output logic              load,
    output logic [TIME_W-1:0] load_time,
    output logic [TIME_W-1:0] edit_time,
    output logic [2:0]        state,
    output logic              ring
);

    localparam int            RT        = (RING_TICKS > 1) ? RING_TICKS : 1;
    localparam int            RW        = (RT > 1) ? $clog2(RT) : 1;
    localparam logic [RW-1:0] RCNT_LAST = RW'(RT - 1);

    rtc_state_e       state_q, state_d;
    rtc_time_t        cur_t;
    rtc_time_t        edit_q, edit_d;
    rtc_time_t        ltime_q, ltime_d;
    logic             load_q, load_d;
    logic [HR_W-1:0]  alm_hh_q, alm_hh_d;
    logic [MIN_W-1:0] alm_mm_q, alm_mm_d;
    logic             armed_q, armed_d;
    logic             match_q, match_d, match_dly_q;
    logic             ring_q, ring_d, ring_clr;
    logic [RW-1:0]    rcnt_q, rcnt_d;
    logic             run_en;
    logic             tick_w;

    assign cur_t = unpack_time(cur_time);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: btn_mode walks the ring of states, otherwise hold.
    always_comb begin
        state_d = state_q;
        if (btn_mode) begin
            case (state_q)
                ST_RUN:     state_d = ST_SET_HR;
                ST_SET_HR:  state_d = ST_SET_MIN;
                ST_SET_MIN: state_d = ST_SET_SEC;
                ST_SET_SEC: state_d = ST_ALM_HR;
                ST_ALM_HR:  state_d = ST_ALM_MIN;
                default:    state_d = ST_RUN;
            endcase
        end
    end

    // Outputs and edit datapath: transition actions on btn_mode, field increments on btn_inc.
    always_comb begin
        run_en   = (state_q == ST_RUN);
        edit_d   = edit_q;
        load_d   = 1'b0;
        ltime_d  = ltime_q;
        alm_hh_d = alm_hh_q;
        alm_mm_d = alm_mm_q;
        armed_d  = armed_q;
        if (btn_mode) begin
            case (state_q)
                ST_RUN: begin
                    edit_d = cur_t;
                end
                ST_SET_SEC: begin
                    load_d    = 1'b1;
                    ltime_d   = edit_q;
                    edit_d.hh = alm_hh_q;
                    edit_d.mm = alm_mm_q;
                    edit_d.ss = '0;
                end
                ST_ALM_MIN: begin
                    alm_hh_d = edit_q.hh;
                    alm_mm_d = edit_q.mm;
                    armed_d  = 1'b1;
                end
                default: ;
            endcase
        end else if (btn_inc) begin
            case (state_q)
                ST_SET_HR, ST_ALM_HR:   edit_d.hh = wrap_inc_hr(edit_q.hh);
                ST_SET_MIN, ST_ALM_MIN: edit_d.mm = wrap_inc_60(edit_q.mm, MIN_MAX);
                ST_SET_SEC:             edit_d.ss = wrap_inc_60(edit_q.ss, SEC_MAX);
                default: ;
            endcase
        end
    end

    // Edit, load and alarm registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            edit_q   <= '0;
            ltime_q  <= '0;
            load_q   <= 1'b0;
            alm_hh_q <= '0;
            alm_mm_q <= '0;
            armed_q  <= 1'b0;
        end else begin
            edit_q   <= edit_d;
            ltime_q  <= ltime_d;
            load_q   <= load_d;
            alm_hh_q <= alm_hh_d;
            alm_mm_q <= alm_mm_d;
            armed_q  <= armed_d;
        end
    end

    rtc_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .en_i   (run_en),
        .tick_o (tick_w)
    );

    // Alarm: a fresh match (re)starts the ring; silence, any mode press or the tick budget ends it.
    always_comb begin
        match_d  = armed_q && (cur_t.hh == alm_hh_q) && (cur_t.mm == alm_mm_q) && (cur_t.ss == '0);
        ring_clr = btn_mode || (btn_inc && run_en) || (tick_w && (rcnt_q == RCNT_LAST));
        ring_d   = ring_q;
        rcnt_d   = rcnt_q;
        if (match_q && !match_dly_q) begin
            ring_d = 1'b1;
            rcnt_d = '0;
        end else if (ring_q) begin
            if (ring_clr) begin
                ring_d = 1'b0;
                rcnt_d = '0;
            end else if (tick_w) begin
                rcnt_d = rcnt_q + RW'(1);
            end
        end
    end

    // Alarm registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            match_q     <= 1'b0;
            match_dly_q <= 1'b0;
            ring_q      <= 1'b0;
            rcnt_q      <= '0;
        end else begin
            match_q     <= match_d;
            match_dly_q <= match_q;
            ring_q      <= ring_d;
            rcnt_q      <= rcnt_d;
        end
    end

    assign tick      = tick_w;
    assign load      = load_q;
    assign load_time = pack_time(ltime_q);
    assign edit_time = pack_time(edit_q);
    assign state     = state_q;
    assign ring      = ring_q;

endmodule

// File: tb/tb_rtc_ctrl.sv
// Scoreboard bench for rtc_ctrl: directed scenarios followed by randomized button/time stimulus.
module tb_rtc_ctrl;

    localparam int TICK_DIV   = 10;
    localparam int RING_TICKS = 60;

    logic        clk;
    logic        reset;
    logic        btn_mode;
    logic        btn_inc;
    logic [16:0] cur_time;
    logic        tick;
    logic        load;
    logic [16:0] load_time;
    logic [16:0] edit_time;
    logic [2:0]  state;
    logic        ring;

    rtc_ctrl #(
        .TICK_DIV   (TICK_DIV),
        .RING_TICKS (RING_TICKS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .cur_time  (cur_time),
        .tick      (tick),
        .load      (load),
        .load_time (load_time),
        .edit_time (edit_time),
        .state     (state),
        .ring      (ring)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic [16:0] ed;
        logic        tk;
        logic        rg;
        logic        ld;
        logic [16:0] lt;
    } exp_t;

    exp_t        exp_q[$];
    logic [16:0] load_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          done    = 1'b0;

    // Reference model: mode index 0..5 (RUN, SET_HR, SET_MIN, SET_SEC, ALM_HR, ALM_MIN)
    int          m_st, e_hh, e_mm, e_ss, a_hh, a_mm, run_cnt, ring_ticks;
    bit          m_armed, m_tick, m_ring, m_load, p1, p2;
    logic [16:0] m_ltime;

    function automatic logic [16:0] tm(input int h, input int m, input int s);
        return {h[4:0], m[5:0], s[5:0]};
    endfunction

    task automatic model_step(input bit rst, input bit md, input bit inc, input logic [16:0] cur);
        int old;
        bit pred;
        if (rst) begin
            m_st = 0; e_hh = 0; e_mm = 0; e_ss = 0; a_hh = 0; a_mm = 0;
            run_cnt = 0; ring_ticks = 0; m_armed = 0; m_tick = 0; m_ring = 0;
            m_load = 0; p1 = 0; p2 = 0; m_ltime = '0;
            return;
        end
        old  = m_st;
        pred = m_armed && (int'(cur[16:12]) == a_hh) && (int'(cur[11:6]) == a_mm) && (cur[5:0] == 6'd0);
        // ring reacts to the match seen two samples ago becoming true
        if (p1 && !p2) begin
            m_ring = 1; ring_ticks = 0;
        end else if (m_ring) begin
            if (m_tick) ring_ticks++;
            if (md || (inc && old == 0) || ring_ticks == RING_TICKS) m_ring = 0;
        end
        p2 = p1; p1 = pred;
        m_load = 0;
        if (md) begin
            if (old == 0) begin
                e_hh = int'(cur[16:12]); e_mm = int'(cur[11:6]); e_ss = int'(cur[5:0]);
            end else if (old == 3) begin
                m_load  = 1;
                m_ltime = tm(e_hh, e_mm, e_ss);
                load_q.push_back(m_ltime);
                e_hh = a_hh; e_mm = a_mm; e_ss = 0;
            end else if (old == 5) begin
                a_hh = e_hh; a_mm = e_mm; m_armed = 1;
            end
            m_st = (old + 1) % 6;
        end else if (inc) begin
            if (old == 1 || old == 4) e_hh = (e_hh + 1) % 24;
            else if (old == 2 || old == 5) e_mm = (e_mm + 1) % 60;
            else if (old == 3) e_ss = (e_ss + 1) % 60;
        end
        if (m_st == 0) run_cnt = (old == 0) ? run_cnt + 1 : 0;
        m_tick = (m_st == 0) && (run_cnt % TICK_DIV == TICK_DIV - 1);
    endtask

    task automatic step(input bit r, input bit md, input bit inc, input logic [16:0] c);
        exp_t e;
        @(negedge clk);
        reset = r; btn_mode = md; btn_inc = inc; cur_time = c;
        model_step(r, md, inc, c);
        e.st = 3'(m_st); e.ed = tm(e_hh, e_mm, e_ss); e.tk = m_tick;
        e.rg = m_ring;   e.ld = m_load;                e.lt = m_ltime;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input logic [16:0] c);
        repeat (n) step(1'b0, 1'b0, 1'b0, c);
    endtask

    task automatic press(input bit md, input bit inc, input logic [16:0] c);
        step(1'b0, md, inc, c);
        step(1'b0, 1'b0, 1'b0, c);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, req);
        end
    endtask

    // Monitor: every cycle pops the model's expected outputs; load pulses pop the load queue.
    initial begin
        exp_t        e;
        exp_t        a;
        logic [16:0] lt;
        while (1) begin
            @(posedge clk);
            #1;
            if (done) break;
            a = {state, edit_time, tick, ring, load, load_time};
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow @%0t: got outputs %h with no expectation", $time, a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL cycle_outputs @%0t: got st=%0d ed=%h tk=%b rg=%b ld=%b lt=%h, expected st=%0d ed=%h tk=%b rg=%b ld=%b lt=%h",
                             $time, a.st, a.ed, a.tk, a.rg, a.ld, a.lt, e.st, e.ed, e.tk, e.rg, e.ld, e.lt);
                end
            end
            if (load === 1'b1) begin
                n_tests++;
                if (load_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL load_unexpected @%0t: got load_time %h, expected no load", $time, load_time);
                end else begin
                    lt = load_q.pop_front();
                    if (load_time !== lt) begin
                        n_fail++;
                        $display("FAIL load_value @%0t: got %h, expected %h", $time, load_time, lt);
                    end
                end
            end
        end
    end

    initial begin
        logic [16:0] c;
        logic [16:0] rc;
        reset = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; cur_time = '0;

        // reset, then free-running RUN
        repeat (3) step(1'b1, 1'b0, 1'b0, tm(1, 2, 3));
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b0, 1'b0, tm(1, 2, 3));
            after_edge();
            chk("tick_after_reset", 64'(tick), 64'((i + 1) % TICK_DIV == TICK_DIV - 1));
            chk("idle_outputs_zero", 64'({load, ring, state, edit_time, load_time}), 64'd0);
        end

        // set time from 10:20:30 to 12:21:59
        c = tm(10, 20, 30);
        press(1'b1, 1'b0, c);
        repeat (2) press(1'b0, 1'b1, c);
        press(1'b1, 1'b0, c);
        press(1'b0, 1'b1, c);
        press(1'b1, 1'b0, c);
        repeat (29) press(1'b0, 1'b1, c);
        step(1'b0, 1'b1, 1'b0, c);
        after_edge();
        chk("load_pulse", 64'(load), 64'd1);
        chk("load_time_set", 64'(load_time), 64'(tm(12, 21, 59)));
        chk("state_alm_hr", 64'(state), 64'd4);
        chk("edit_shows_alarm", 64'(edit_time), 64'(tm(0, 0, 0)));
        step(1'b0, 1'b0, 1'b0, c);
        after_edge();
        chk("load_one_cycle", 64'(load), 64'd0);
        chk("load_time_held", 64'(load_time), 64'(tm(12, 21, 59)));

        // alarm 06:30, back to RUN
        repeat (6) press(1'b0, 1'b1, c);
        press(1'b1, 1'b0, c);
        repeat (30) press(1'b0, 1'b1, c);
        step(1'b0, 1'b1, 1'b0, c);
        after_edge();
        chk("state_back_run", 64'(state), 64'd0);
        idle(5, tm(6, 29, 59));
        step(1'b0, 1'b0, 1'b0, tm(6, 30, 0));
        after_edge();
        chk("ring_not_yet", 64'(ring), 64'd0);
        step(1'b0, 1'b0, 1'b0, tm(6, 30, 0));
        after_edge();
        chk("ring_two_cycles", 64'(ring), 64'd1);
        step(1'b0, 1'b0, 1'b1, tm(6, 30, 1));
        after_edge();
        chk("ring_inc_clear", 64'(ring), 64'd0);

        // auto-clear after RING_TICKS ticks
        idle(3, tm(6, 30, 1));
        idle(2, tm(6, 30, 0));
        idle(300, tm(6, 31, 0));
        chk("ring_still_on", 64'(ring), 64'd1);
        idle(320, tm(6, 31, 0));
        chk("ring_auto_clear", 64'(ring), 64'd0);

        // field wrap and mode+inc priority
        c = tm(23, 59, 10);
        press(1'b1, 1'b0, c);
        step(1'b0, 1'b0, 1'b1, c);
        after_edge();
        chk("hr_wrap", 64'(edit_time), 64'(tm(0, 59, 10)));
        press(1'b1, 1'b0, c);
        step(1'b0, 1'b0, 1'b1, c);
        after_edge();
        chk("min_wrap", 64'(edit_time), 64'(tm(0, 0, 10)));
        press(1'b0, 1'b1, c);
        step(1'b0, 1'b1, 1'b1, c);
        after_edge();
        chk("mode_inc_state", 64'(state), 64'd3);
        chk("mode_inc_edit", 64'(edit_time), 64'(tm(0, 1, 10)));

        // reset while in SET_SEC
        step(1'b1, 1'b0, 1'b0, c);
        step(1'b1, 1'b0, 1'b0, c);
        after_edge();
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_no_load", 64'({load, ring}), 64'd0);
        idle(20, tm(0, 0, 0));
        idle(20, tm(6, 30, 0));
        chk("reset_disarmed", 64'(ring), 64'd0);

        // randomized phase
        rc = tm(3, 4, 5);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 2) == 0)
                    rc = tm(a_hh, a_mm, int'($urandom_range(0, 1)));
                else
                    rc = tm(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)), int'($urandom_range(0, 59)));
            end
            step($urandom_range(0, 999) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 7) == 0, rc);
        end

        @(posedge clk);
        #2;
        done = 1'b1;
        chk("load_queue_drained", 64'(load_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rtc_ctrl.md
# rtc_ctrl

Controller that sequences the real-time clock counter (`rt_clock`). It generates the 1 Hz count enable and runs a button-driven set-mode FSM to edit and load a new time. It also stores an alarm time and raises a ring output on a match. It sits between the debounced user buttons and the clock counter, which consumes `tick`, `load` and `load_time`.

## Interface
- `TICK_DIV`, default 100000000: clk cycles per `tick` (benches use 10).
- `RING_TICKS`, default 60: ticks the alarm rings before auto-clear.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `btn_mode`  in  1  one-cycle pulse, already debounced; advances FSM.
- `btn_inc`  in  1  one-cycle pulse, already debounced; increments the field being edited / silences alarm.
- `cur_time`  in  17  {hh[16:12], mm[11:6], ss[5:0]} from the clock counter, binary.
- `tick`  out  1  one-cycle count enable to the counter.
- `load`  out  1  one-cycle pulse; counter loads `load_time`.
- `load_time`  out  17  time to load, same packing.
- `edit_time`  out  17  value shown while editing (time or alarm fields).
- `state`  out  3  FSM state encoding.
- `ring`  out  1  alarm active.

## Operation
- States (encoding): RUN=0, SET_HR=1, SET_MIN=2, SET_SEC=3, ALM_HR=4, ALM_MIN=5.
- `btn_mode` transitions: RUN→SET_HR→SET_MIN→SET_SEC→ALM_HR→ALM_MIN→RUN. With no `btn_mode`, the state holds.
- RUN→SET_HR copies `cur_time` into the edit register.
- SET_SEC→ALM_HR:
  - pulses `load` with `load_time` = edit register;
  - copies the alarm register (hh, mm, ss=0) into `edit_time`.
- ALM_MIN→RUN writes the edited hh:mm to the alarm register and sets `armed`.
- `btn_inc` in a SET_*/ALM_* state increments only the current field, modulo:
  - hh: 23→0
  - mm: 59→0
  - ss: 59→0
  - other fields are unchanged.
- Simultaneous `btn_mode` and `btn_inc`: `btn_mode` wins and the increment is discarded.
- Prescaler `pcnt` (width clog2(TICK_DIV)):
  - counts 0..TICK_DIV-1 in RUN only;
  - is held at 0 in all other states, so the counter is frozen while setting.
- `tick` = (state==RUN) && (pcnt==TICK_DIV-1).
- Alarm:
  - `match` = `armed` && cur_time.hh==alm_hh && cur_time.mm==alm_mm && cur_time.ss==0, registered.
  - A rising edge of registered `match` sets `ring` and clears the ring counter.
  - `ring` clears on `btn_inc` in RUN, on RING_TICKS ticks elapsed, or on any `btn_mode`.
- In RUN, `btn_inc` does nothing except clear `ring`.

## Timing
- Reset values:
  - state=RUN, pcnt=0;
  - `tick`=0, `load`=0, `load_time`=0, `edit_time`=0, `ring`=0;
  - `armed`=0, alarm register=00:00.
- Reset mid-edit abandons the edit and issues no `load`.
- `state`, `edit_time`, `load` and `load_time` are registered and update the cycle after the button pulse.
- `load` is high for exactly one cycle; `load_time` is held until the next load.
- First `tick` after re-entering RUN (or after reset) occurs TICK_DIV cycles later: cycle index TICK_DIV-1, counting the first RUN cycle as 0.
- `tick` has period exactly TICK_DIV cycles in steady RUN.
- `ring` rises 2 cycles after `cur_time` first presents the matching value: 1 cycle for the match register, 1 cycle for the ring register.
- Ring auto-clear happens on the cycle after the RING_TICKS-th `tick` counted since `ring` rose.

## Structure
- Shared package `rtc_pkg`:
  - state enum;
  - field width constants HR_W=5, MIN_W=6, SEC_W=6, TIME_W=17;
  - field limits 23/59;
  - pack/unpack helpers.
- One sub-module `rtc_prescaler` (pcnt, enable input, `tick` output). FSM, edit logic and alarm stay in `rtc_ctrl`.

## Test plan
- Reset, TICK_DIV=10, hold RUN: `tick` high at cycles 9, 19, 29 after reset release; all other outputs 0.
- Set time:
  - cur_time=10:20:30, then mode, inc×2, mode, inc, mode, inc×29, mode.
  - Required: `load` pulse with `load_time`=12:21:59; state=ALM_HR; no `tick` while in SET_*.
- Wrap: in SET_HR with hh=23, inc → hh=0; in SET_MIN with mm=59, inc → mm=0.
- Simultaneous mode+inc in SET_MIN: state→SET_SEC, mm unchanged.
- Alarm:
  - set alarm 06:30 and return to RUN; drive cur_time 06:29:59 then 06:30:00.
  - `ring`=1 two cycles after 06:30:00 is presented; inc clears it next cycle.
  - With no inc, it clears after 60 ticks.
- Reset asserted in SET_SEC: state=RUN, no `load`, `armed`=0, `ring`=0.
